// File: rtl/sr_lock_arbiter_pkg.sv
// Shared types, SR command encoding and round-robin pick helper for the
// hardware mutex (sr_lock_arbiter).
package sr_lock_arbiter_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    // SR flag command {s, r}
    localparam logic [1:0] SR_HOLD = 2'b00;
    localparam logic [1:0] SR_SET  = 2'b10;
    localparam logic [1:0] SR_CLR  = 2'b01;

    // Round-robin pick over up to 16 requesters.
    // Searches upward from ptr with wrap at nreq.
    // Returns {valid, index[3:0]}.
    function automatic logic [4:0] rr_pick(input logic [15:0] req,
                                           input logic [3:0]  ptr,
                                           input logic [4:0]  nreq);
        logic [4:0] res;
        logic [4:0] sum;
        logic [4:0] idx;
        res = 5'd0;
        for (int i = 0; i < 16; i++) begin
            sum = 5'(ptr) + 5'(i);
            if (sum >= nreq) begin
                idx = sum - nreq;
            end else begin
                idx = sum;
            end
            if ((5'(i) < nreq) && !res[4] && req[idx[3:0]]) begin
                res = {1'b1, idx[3:0]};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/sr_flag_cell.sv
// Single SR ownership flag: posedge flop, synchronous reset to 0,
// complementary output qn is a continuous inverse of q.
module sr_flag_cell
    import sr_lock_arbiter_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic s,
    input  logic r,
    output logic q,
    output logic qn
);

    logic q_r;

    // Flag state: set, clear or hold according to the {s, r} command
    always_ff @(posedge clk) begin
        if (rst) begin
            q_r <= 1'b0;
        end else begin
            case ({s, r})
                SR_SET:  q_r <= 1'b1;
                SR_CLR:  q_r <= 1'b0;
                SR_HOLD: q_r <= q_r;
                default: q_r <= q_r;
            endcase
        end
    end

    assign q  = q_r;
    assign qn = ~q_r;

endmodule

// File: rtl/sr_lock_arbiter_chk.sv
// Invariant checks for the lock arbiter: legal SR commands, one-hot grant,
// flag outputs consistent with the grant vector.
module sr_lock_arbiter_chk #(
    parameter int NREQ = 4
) (
    input logic            clk,
    input logic            rst,
    input logic            s,
    input logic            r,
    input logic [NREQ-1:0] grant,
    input logic            busy,
    input logic            free
);

    a_sr_legal: assert property (@(posedge clk) disable iff (rst) !(s && r))
        else $error("sr_lock_arbiter: S and R asserted together");

    a_grant_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(grant))
        else $error("sr_lock_arbiter: grant not one-hot");

    a_busy_grant: assert property (@(posedge clk) disable iff (rst) busy == (|grant))
        else $error("sr_lock_arbiter: busy disagrees with grant");

    a_free_busy: assert property (@(posedge clk) disable iff (rst) free == !busy)
        else $error("sr_lock_arbiter: free is not the inverse of busy");

endmodule

// File: rtl/sr_lock_arbiter.sv
// Hardware mutex: round-robin arbitration of NREQ requesters onto one SR
// ownership flag, with optional forced release after HOLD_MAX cycles.
module sr_lock_arbiter
    import sr_lock_arbiter_pkg::*;
#(
    parameter int NREQ     = 4,
    parameter int IDW      = 2,
    parameter int HOLD_MAX = 0,
    parameter int CNTW     = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    input  logic [NREQ-1:0] rel,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  owner,
    output logic            busy,
    output logic            free,
    output logic            timeout
);

    localparam int              HOLD_LAST_I = (HOLD_MAX > 0) ? (HOLD_MAX - 1) : 0;
    localparam logic [CNTW-1:0] HOLD_LAST   = CNTW'(HOLD_LAST_I);
    localparam logic [CNTW-1:0] CNT_MAX     = {CNTW{1'b1}};
    localparam logic [CNTW-1:0] CNT_ONE     = {{(CNTW-1){1'b0}}, 1'b1};
    localparam logic [CNTW-1:0] CNT_ZERO    = {CNTW{1'b0}};
    localparam logic [NREQ-1:0] GRANT_LSB   = {{(NREQ-1){1'b0}}, 1'b1};
    localparam logic [NREQ-1:0] GRANT_NONE  = {NREQ{1'b0}};
    localparam logic [IDW-1:0]  IDX_ZERO    = {IDW{1'b0}};
    localparam logic [3:0]      LAST_IDX    = 4'(NREQ - 1);

    state_t          state_r, next_state_s;
    logic [NREQ-1:0] grant_r, next_grant_s;
    logic [IDW-1:0]  owner_r, next_owner_s;
    logic [IDW-1:0]  ptr_r, next_ptr_s;
    logic [CNTW-1:0] cnt_r, next_cnt_s;
    logic            timeout_r, next_timeout_s;
    logic [1:0]      sr_cmd_s;
    logic [4:0]      pick_s;
    logic [3:0]      pick_idx_s;
    logic            sr_s, sr_r_s;

    assign pick_s     = rr_pick(16'(req), 4'(ptr_r), 5'(NREQ));
    assign pick_idx_s = pick_s[3:0];

    // Next-state decision: grant in IDLE, release or timeout in LOCKED
    always_comb begin
        next_state_s   = state_r;
        next_grant_s   = grant_r;
        next_owner_s   = owner_r;
        next_ptr_s     = ptr_r;
        next_cnt_s     = cnt_r;
        next_timeout_s = 1'b0;
        sr_cmd_s       = SR_HOLD;
        case (state_r)
            IDLE: begin
                if (pick_s[4]) begin
                    next_state_s = LOCKED;
                    next_grant_s = GRANT_LSB << pick_idx_s;
                    next_owner_s = IDW'(pick_idx_s);
                    next_cnt_s   = CNT_ZERO;
                    sr_cmd_s     = SR_SET;
                    if (pick_idx_s == LAST_IDX) begin
                        next_ptr_s = IDX_ZERO;
                    end else begin
                        next_ptr_s = IDW'(pick_idx_s + 4'd1);
                    end
                end else begin
                    next_state_s = IDLE;
                end
            end
            LOCKED: begin
                if (rel[owner_r]) begin
                    // An owner release wins over a coincident timeout
                    next_state_s = IDLE;
                    next_grant_s = GRANT_NONE;
                    sr_cmd_s     = SR_CLR;
                end else if ((HOLD_MAX > 0) && (cnt_r == HOLD_LAST)) begin
                    // Forced release; rr pointer already points past the owner
                    next_state_s   = IDLE;
                    next_grant_s   = GRANT_NONE;
                    next_timeout_s = 1'b1;
                    sr_cmd_s       = SR_CLR;
                end else if (cnt_r != CNT_MAX) begin
                    next_cnt_s = cnt_r + CNT_ONE;
                end else begin
                    next_cnt_s = cnt_r;
                end
            end
            default: begin
                next_state_s = IDLE;
                next_grant_s = GRANT_NONE;
                sr_cmd_s     = SR_CLR;
            end
        endcase
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            grant_r   <= GRANT_NONE;
            owner_r   <= IDX_ZERO;
            ptr_r     <= IDX_ZERO;
            cnt_r     <= CNT_ZERO;
            timeout_r <= 1'b0;
        end else begin
            state_r   <= next_state_s;
            grant_r   <= next_grant_s;
            owner_r   <= next_owner_s;
            ptr_r     <= next_ptr_s;
            cnt_r     <= next_cnt_s;
            timeout_r <= next_timeout_s;
        end
    end

    assign sr_s   = sr_cmd_s[1];
    assign sr_r_s = sr_cmd_s[0];

    sr_flag_cell u_flag (
        .clk (clk),
        .rst (rst),
        .s   (sr_s),
        .r   (sr_r_s),
        .q   (busy),
        .qn  (free)
    );

    sr_lock_arbiter_chk #(.NREQ(NREQ)) u_chk (
        .clk   (clk),
        .rst   (rst),
        .s     (sr_s),
        .r     (sr_r_s),
        .grant (grant_r),
        .busy  (busy),
        .free  (free)
    );

    assign grant   = grant_r;
    assign owner   = owner_r;
    assign timeout = timeout_r;

endmodule

// File: tb/tb_sr_lock_arbiter.sv
// Scoreboard bench for sr_lock_arbiter (NREQ=4, HOLD_MAX=5): directed
// scenarios followed by random traffic, checked against a cycle-level
// reference model of the mutex rules.
module tb_sr_lock_arbiter;

    localparam int NREQ     = 4;
    localparam int IDW      = 2;
    localparam int HOLD_MAX = 5;
    localparam int CNTW     = 8;

    typedef struct packed {
        logic [NREQ-1:0] grant;
        logic [IDW-1:0]  owner;
        logic            busy;
        logic            free;
        logic            timeout;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [NREQ-1:0] req = '0;
    logic [NREQ-1:0] rel = '0;
    logic [NREQ-1:0] grant;
    logic [IDW-1:0]  owner;
    logic            busy;
    logic            free;
    logic            timeout;

    exp_t exp_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    // reference model state
    bit m_locked = 0;
    int m_owner  = 0;
    int m_ptr    = 0;
    int m_cyc    = 0;
    int m_gcyc   = 0;

    always #5 clk = ~clk;

    sr_lock_arbiter #(
        .NREQ(NREQ), .IDW(IDW), .HOLD_MAX(HOLD_MAX), .CNTW(CNTW)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .rel(rel),
        .grant(grant), .owner(owner), .busy(busy), .free(free), .timeout(timeout)
    );

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] want);
        n_cmp++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s at t=%0t: got %0h expected %0h", name, $time, act, want);
        end
    endtask

    // One clock: drive inputs, apply the mutex rules at the edge, queue the result
    task automatic cyc(input logic r_i, input logic [NREQ-1:0] q_i, input logic [NREQ-1:0] l_i);
        exp_t e;
        bit   found;
        bit   to;
        @(negedge clk);
        rst = r_i; req = q_i; rel = l_i;
        @(posedge clk);
        m_cyc++;
        to = 0;
        if (r_i) begin
            m_locked = 0; m_owner = 0; m_ptr = 0;
        end else if (!m_locked) begin
            found = 0;
            for (int i = 0; i < NREQ; i++) begin
                int c;
                c = (m_ptr + i) % NREQ;
                if (!found && q_i[c]) begin
                    found = 1; m_locked = 1; m_owner = c;
                    m_ptr = (c + 1) % NREQ; m_gcyc = m_cyc;
                end
            end
        end else if (l_i[m_owner]) begin
            m_locked = 0;
        end else if (m_cyc - m_gcyc == HOLD_MAX) begin
            m_locked = 0; to = 1;
        end
        e.grant   = m_locked ? (4'b0001 << m_owner) : 4'b0000;
        e.owner   = IDW'(m_owner);
        e.busy    = m_locked;
        e.free    = !m_locked;
        e.timeout = to;
        exp_q.push_back(e);
    endtask

    // Monitor: compare each presented output cycle with the queued expectation
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("grant",   8'(grant),   8'(e.grant));
            check("owner",   8'(owner),   8'(e.owner));
            check("busy",    8'(busy),    8'(e.busy));
            check("free",    8'(free),    8'(e.free));
            check("timeout", 8'(timeout), 8'(e.timeout));
        end
    end

    initial begin
        logic [NREQ-1:0] rr;
        // reset then idle
        cyc(1'b1, 4'b0000, 4'b0000);
        cyc(1'b1, 4'b0000, 4'b0000);
        repeat (2) cyc(1'b0, 4'b0000, 4'b0000);
        // single requester, released after a few cycles
        cyc(1'b0, 4'b0100, 4'b0000);
        repeat (2) cyc(1'b0, 4'b0100, 4'b0000);
        cyc(1'b0, 4'b0100, 4'b0100);
        cyc(1'b0, 4'b0000, 4'b0000);
        // round-robin fairness with everyone requesting
        cyc(1'b1, 4'b0000, 4'b0000);
        repeat (5) begin
            cyc(1'b0, 4'b1111, 4'b0000);
            cyc(1'b0, 4'b1111, 4'b0001 << m_owner);
        end
        cyc(1'b0, 4'b0000, 4'b0000);
        // foreign release ignored
        cyc(1'b0, 4'b0010, 4'b0000);
        cyc(1'b0, 4'b0010, 4'b0001);
        cyc(1'b0, 4'b0010, 4'b1000);
        cyc(1'b0, 4'b0000, 4'b0000);
        cyc(1'b0, 4'b0000, 4'b0010);
        cyc(1'b0, 4'b0000, 4'b0000);
        // timeout with two requesters held
        cyc(1'b1, 4'b0000, 4'b0000);
        repeat (14) cyc(1'b0, 4'b0011, 4'b0000);
        cyc(1'b0, 4'b0000, 4'b0011);
        cyc(1'b0, 4'b0000, 4'b0000);
        // reset mid-lock
        cyc(1'b0, 4'b1000, 4'b0000);
        cyc(1'b0, 4'b1000, 4'b0000);
        cyc(1'b1, 4'b1000, 4'b0000);
        cyc(1'b0, 4'b0000, 4'b0000);
        // release on the expiry edge: no timeout pulse
        cyc(1'b0, 4'b0001, 4'b0000);
        repeat (4) cyc(1'b0, 4'b0001, 4'b0000);
        cyc(1'b0, 4'b0001, 4'b0001);
        cyc(1'b0, 4'b0000, 4'b0000);
        // random traffic
        for (int k = 0; k < 2000; k++) begin
            rr = ($urandom_range(0, 3) == 0) ? NREQ'($urandom) : 4'b0000;
            if (m_locked && ($urandom_range(0, 2) == 0)) begin
                rr = rr | (4'b0001 << m_owner);
            end
            cyc(($urandom_range(0, 99) == 0) ? 1'b1 : 1'b0, NREQ'($urandom), rr);
        end
        @(negedge clk);
        @(negedge clk);
        check("queue_drained", 8'(exp_q.size()), 8'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/sr_lock_arbiter.md
Name: sr_lock_arbiter

Overview:
- Hardware mutex: up to NREQ requesters share one SR-style ownership flag.
- Round-robin arbiter drives set/clear pulses into a single SR flag cell and grants exclusive ownership to one requester at a time.
- Optional hold timeout forcibly releases a requester that stalls.
- Sits between requester blocks and any shared resource that is guarded by a busy flag.

Parameters:
- NREQ, 4, number of requesters (2..16)
- IDW, 2, width of owner index, equals ceil(log2(NREQ))
- HOLD_MAX, 0, max cycles a grant may be held; 0 disables timeout
- CNTW, 8, hold counter width; HOLD_MAX must fit in CNTW bits

Ports:
- clk  input  1  single clock; all state updates on posedge
- rst  input  1  synchronous, active-high reset
- req  input  NREQ  level request per requester
- rel  input  NREQ  release strobe per requester
- grant  output  NREQ  one-hot ownership grant, registered
- owner  output  IDW  index of current/last owner, registered
- busy  output  1  flag cell Q: lock held
- free  output  1  flag cell QN, always ~busy (continuous)
- timeout  output  1  one-cycle pulse on forced release

Behaviour:
- Interface: one clock (clk). Reset (rst) is synchronous and active-high.
- Reset values: grant=0, owner=0, busy=0, free=1, timeout=0, rr pointer=0, hold counter=0, state=IDLE.
- Reset mid-lock drops the grant immediately at that edge. No release pulse is generated.
- FSM states: IDLE, LOCKED.
- IDLE behaviour:
  - If req != 0 at edge k, pick the first asserted req searching upward from rr pointer, with wrap NREQ-1 -> 0.
  - From edge k: grant[winner]=1, owner=winner, busy=1, rr pointer=winner+1 (mod NREQ), hold counter=0, go to LOCKED.
  - Grant latency is one edge from req.
- LOCKED behaviour:
  - grant, owner and busy are held.
  - Hold counter increments each cycle and saturates at all-ones.
- Release: rel[owner]=1 at an edge -> grant=0, busy=0, state=IDLE.
  - The next grant is possible at the following edge, so there is at least one free cycle between owners.
- Ignored inputs:
  - rel from a non-owner, and any rel in IDLE.
  - The owner dropping req does not release; only rel releases.
  - Multiple rel bits: only rel[owner] is evaluated.
- Timeout (HOLD_MAX>0):
  - When the counter equals HOLD_MAX-1 and rel[owner]=0, the next edge forces a release.
  - Forced release: grant=0, busy=0, timeout=1 for exactly one cycle, state=IDLE.
  - The rr pointer is unchanged, since it already advanced past the owner at grant time.
- Simultaneous rel[owner] and timeout expiry: treated as a normal release, timeout stays 0.
- Flag cell semantics: S=1,R=0 sets; S=0,R=1 clears; 00 holds.
  - S=R=1 is illegal; the controller never drives it (assertion required).
  - Flag updates at the same edge as the grant/release decision, so busy == |grant at all times.
- Invariants: grant is one-hot or zero; free == ~busy; owner changes only on a new grant.

Decomposition:
- Shared package:
  - state enum (IDLE, LOCKED)
  - localparam for the SR command encoding (HOLD, SET, CLR)
  - function rr_pick(req, ptr) returning the winning index plus a valid bit
- One natural sub-module: sr_flag_cell.
  - Ports: clk, rst, s, r, q, qn.
  - Posedge SR flop with synchronous reset to 0; qn is a continuous ~q.
  - Instanced once to produce busy/free.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, req=0 -> grant=0000, busy=0, free=1, owner=0, timeout=0 throughout.
- Single requester: req=0100 at edge 3 -> grant=0100, owner=2, busy=1 from edge 3. rel=0100 at edge 6 -> grant=0000, busy=0 at edge 6.
- Round-robin fairness: req=1111 held, owner pulses rel 1 cycle after each grant -> grant order 0001,0010,0100,1000,0001, one free cycle between grants.
- Foreign release ignored: owner=1, rel=0001 and rel=1000 pulsed -> grant stays 0010, busy stays 1. rel=0010 -> released.
- Timeout, HOLD_MAX=5: grant 0001 at edge 10, no rel -> forced release at edge 15, timeout=1 only during cycle 15-16. With req=0011 held, grant=0010 at edge 16.
- Reset mid-lock and rel/timeout collision: rst at edge 4 while grant=1000 -> all outputs at reset values at edge 4. With HOLD_MAX=5, rel[owner] at the expiry edge -> release with timeout=0.
